// File: rtl/shell_sprite_render.sv
// Shell sprite pixel stage: scan position -> ROM address, ROM latency alignment,
// colour-key transparency, and a per-frame opaque pixel counter.
//
// Ports:
//   clk, rst_n          pixel clock, synchronous active-low reset
//   pix_x, pix_y        scan position, qualified by pix_valid
//   frame_start         one-cycle pulse per frame, loads the sprite shadow registers
//   spr_x, spr_y, spr_en sprite position/enable from the CPU register file
//   rom_addr            registered address into the sprite ROM
//   rom_data            ROM word, valid one cycle after rom_addr
//   pix_rgb, pix_hit    registered pixel colour and opaque-hit flag
//   out_valid           pix_valid delayed to line up with pix_rgb
//   opaque_cnt          opaque pixel count of the previous frame
module shell_sprite_render #(
    parameter int unsigned SPR_W  = 40,
    parameter int unsigned SPR_H  = 40,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned CRD_W  = 11,
    parameter logic [15:0] KEY    = 16'hF81F
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CRD_W-1:0]  pix_x,
    input  logic [CRD_W-1:0]  pix_y,
    input  logic              pix_valid,
    input  logic              frame_start,
    input  logic [CRD_W-1:0]  spr_x,
    input  logic [CRD_W-1:0]  spr_y,
    input  logic              spr_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [15:0]       pix_rgb,
    output logic              pix_hit,
    output logic              out_valid,
    output logic [ADDR_W:0]   opaque_cnt
);

    localparam int unsigned   CNT_W     = ADDR_W + 1;
    localparam int unsigned   SUM_W     = CRD_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam bit            USE_SHIFT = (SPR_W == 40);

    logic [CRD_W-1:0]  spr_x_s;
    logic [CRD_W-1:0]  spr_y_s;
    logic              spr_en_s;

    logic              in_box_d1;
    logic              in_box_d2;
    logic              valid_d1;
    logic              valid_d2;
    logic [CNT_W-1:0]  acc;

    logic [SUM_W-1:0]  x_end;
    logic [SUM_W-1:0]  y_end;
    logic [CRD_W-1:0]  dx;
    logic [CRD_W-1:0]  dy;
    logic              in_box;
    logic [ADDR_W-1:0] addr_c;
    logic              hit;
    logic [CNT_W-1:0]  acc_inc;

    // Box test against the shadow position; the widened end sums keep a sprite
    // hanging off the right/bottom screen edge from wrapping back to column 0.
    always_comb begin
        x_end  = SUM_W'(spr_x_s) + SUM_W'(SPR_W);
        y_end  = SUM_W'(spr_y_s) + SUM_W'(SPR_H);
        dx     = pix_x - spr_x_s;
        dy     = pix_y - spr_y_s;
        in_box = pix_valid & spr_en_s
               & (pix_x >= spr_x_s) & ({1'b0, pix_x} < x_end)
               & (pix_y >= spr_y_s) & ({1'b0, pix_y} < y_end);
        addr_c = '0;
        if (in_box) begin
            if (USE_SHIFT) begin
                // dy*40 as dy*32 + dy*8
                addr_c = (ADDR_W'(dy) << 5) + (ADDR_W'(dy) << 3) + ADDR_W'(dx);
            end else begin
                addr_c = ADDR_W'(32'(dy) * SPR_W + 32'(dx));
            end
        end
    end

    // Output-stage hit and the saturating accumulator increment.
    always_comb begin
        hit     = in_box_d2 & (rom_data != KEY);
        acc_inc = acc;
        if (hit && (acc != CNT_MAX)) begin
            acc_inc = acc + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spr_x_s    <= '0;
            spr_y_s    <= '0;
            spr_en_s   <= 1'b0;
            rom_addr   <= '0;
            in_box_d1  <= 1'b0;
            valid_d1   <= 1'b0;
            in_box_d2  <= 1'b0;
            valid_d2   <= 1'b0;
            pix_hit    <= 1'b0;
            pix_rgb    <= '0;
            out_valid  <= 1'b0;
            acc        <= '0;
            opaque_cnt <= '0;
        end else begin
            rom_addr  <= addr_c;
            in_box_d1 <= in_box;
            valid_d1  <= pix_valid;
            in_box_d2 <= in_box_d1;
            valid_d2  <= valid_d1;
            pix_hit   <= hit;
            pix_rgb   <= hit ? rom_data : 16'h0000;
            out_valid <= valid_d2;

            // The pixel completing on the frame_start edge belongs to the closing frame.
            if (frame_start) begin
                spr_x_s    <= spr_x;
                spr_y_s    <= spr_y;
                spr_en_s   <= spr_en;
                opaque_cnt <= acc_inc;
                acc        <= '0;
            end else begin
                acc        <= acc_inc;
            end
        end
    end

endmodule

// File: tb/tb_shell_sprite_render.sv
module tb_shell_sprite_render;

    localparam int unsigned SPR_W   = 40;
    localparam int unsigned SPR_H   = 40;
    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned CRD_W   = 11;
    localparam logic [15:0] KEY     = 16'hF81F;
    localparam int          CNT_MAX = 4095;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CRD_W-1:0]  pix_x = '0;
    logic [CRD_W-1:0]  pix_y = '0;
    logic              pix_valid = 1'b0;
    logic              frame_start = 1'b0;
    logic [CRD_W-1:0]  spr_x = '0;
    logic [CRD_W-1:0]  spr_y = '0;
    logic              spr_en = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [15:0]       pix_rgb;
    logic              pix_hit;
    logic              out_valid;
    logic [ADDR_W:0]   opaque_cnt;

    shell_sprite_render #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W), .CRD_W(CRD_W), .KEY(KEY)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .frame_start(frame_start),
        .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_rgb(pix_rgb), .pix_hit(pix_hit), .out_valid(out_valid),
        .opaque_cnt(opaque_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous sprite ROM: one-cycle read latency.
    logic [15:0] rom [0:2047];
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        bit          hit;
        logic [15:0] rgb;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    // Reference model state
    int m_sx, m_sy, m_acc, exp_addr, exp_cnt;
    bit m_en, pend0, pend1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t", nm, act, act, req, req, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    // Drive one pixel for the coming edge and advance the model.
    task automatic step(input int x, input int y, input bit v, input bit fs);
        bit inb;
        bit h;
        bit hnow;
        int a;
        @(negedge clk);
        rst_n       = 1'b1;
        pix_x       = CRD_W'(x);
        pix_y       = CRD_W'(y);
        pix_valid   = v;
        frame_start = fs;
        inb = v && m_en && (x >= m_sx) && (x < m_sx + SPR_W) && (y >= m_sy) && (y < m_sy + SPR_H);
        a   = inb ? (y - m_sy) * SPR_W + (x - m_sx) : 0;
        h   = inb && (rom[a] != KEY);
        if (v) exp_q.push_back('{hit: h, rgb: (h ? rom[a] : 16'h0000)});
        exp_addr = a;
        hnow  = pend1;
        pend1 = pend0;
        pend0 = h;
        if (fs) begin
            exp_cnt = sat(m_acc + int'(hnow));
            m_acc   = 0;
            m_sx    = int'(spr_x);
            m_sy    = int'(spr_y);
            m_en    = spr_en;
        end else begin
            m_acc = sat(m_acc + int'(hnow));
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n       = 1'b0;
        frame_start = 1'b0;
        pix_valid   = 1'b1;
        pix_x       = spr_x;
        pix_y       = spr_y;
        exp_q.delete();
        m_sx = 0; m_sy = 0; m_en = 1'b0; m_acc = 0;
        pend0 = 1'b0; pend1 = 1'b0;
        exp_addr = 0; exp_cnt = 0;
        repeat (cycles) @(posedge clk);
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0);
    endtask

    task automatic set_spr(input int x, input int y, input bit en);
        spr_x  = CRD_W'(x);
        spr_y  = CRD_W'(y);
        spr_en = en;
    endtask

    task automatic rand_scan(input int n, input int x0, input int x1, input int y0, input int y1,
                             input int fs_permille);
        for (int i = 0; i < n; i++) begin
            step(int'($urandom_range(x1, x0)), int'($urandom_range(y1, y0)),
                 ($urandom_range(99, 0) < 85), ($urandom_range(999, 0) < fs_permille));
        end
    endtask

    task automatic scan_box(input int reps);
        for (int r = 0; r < reps; r++)
            for (int y = 0; y < SPR_H; y++)
                for (int x = 0; x < SPR_W; x++)
                    step(m_sx + x, m_sy + y, 1'b1, 1'b0);
    endtask

    task automatic check_cnt_now(input string nm, input int req);
        @(posedge clk);
        #1;
        chk(nm, 32'(opaque_cnt), 32'(req));
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a valid pixel.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
                chk("opaque_cnt", 32'(opaque_cnt), 32'(exp_cnt));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pix_hit", 32'(pix_hit), 32'(e.hit));
                        chk("pix_rgb", 32'(pix_rgb), 32'(e.rgb));
                    end
                end else begin
                    chk("idle_pix_hit", 32'(pix_hit), 32'd0);
                    chk("idle_pix_rgb", 32'(pix_rgb), 32'd0);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 2048; i++)
            rom[i] = ($urandom_range(3, 0) == 0) ? KEY : 16'($urandom);
        rom[0]    = 16'h1234;
        rom[5]    = KEY;
        rom[1599] = 16'h0BEE;

        do_reset(3);
        idle(2);

        // Basic hit, last pixel, first outside pixels, transparency
        set_spr(100, 50, 1'b1);
        step(0, 0, 1'b0, 1'b1);
        step(100, 50, 1'b1, 1'b0);
        step(139, 89, 1'b1, 1'b0);
        step(140, 89, 1'b1, 1'b0);
        step(139, 90, 1'b1, 1'b0);
        step(105, 50, 1'b1, 1'b0);
        step(99, 50, 1'b1, 1'b0);
        idle(3);
        rand_scan(400, 90, 150, 40, 100, 0);

        // Shadow latching: CPU moves the sprite mid-frame
        set_spr(300, 50, 1'b1);
        rand_scan(300, 90, 350, 40, 100, 0);
        step(0, 0, 1'b0, 1'b1);
        rand_scan(300, 90, 350, 40, 100, 0);
        step(310, 60, 1'b1, 1'b1);
        step(110, 60, 1'b1, 1'b0);
        idle(3);

        // Edge wrap near the right screen edge
        set_spr(2030, 10, 1'b1);
        step(0, 0, 1'b0, 1'b1);
        step(5, 20, 1'b1, 1'b0);
        step(2047, 20, 1'b1, 1'b0);
        for (int i = 0; i < 200; i++)
            step((2020 + int'($urandom_range(50, 0))) % 2048, int'($urandom_range(60, 0)),
                 1'b1, 1'b0);
        idle(3);

        // Random frames with occasional frame_start coinciding with valid pixels
        set_spr(100, 50, 1'b1);
        step(0, 0, 1'b0, 1'b1);
        rand_scan(600, 90, 150, 40, 100, 10);
        idle(3);

        // Counter over an all-opaque ROM
        for (int i = 0; i < 2048; i++) begin
            rom[i] = 16'($urandom);
            if (rom[i] == KEY) rom[i] = 16'h0000;
        end
        set_spr(100, 50, 1'b1);
        step(0, 0, 1'b0, 1'b1);
        scan_box(1);
        idle(2);
        set_spr(100, 50, 1'b0);
        step(0, 0, 1'b0, 1'b1);
        check_cnt_now("cnt_full_frame", 1600);
        scan_box(1);
        idle(2);
        set_spr(100, 50, 1'b1);
        step(0, 0, 1'b0, 1'b1);
        check_cnt_now("cnt_disabled_frame", 0);

        // Saturation: the same sprite area scanned three times in one frame
        scan_box(3);
        idle(2);
        step(0, 0, 1'b0, 1'b1);
        check_cnt_now("cnt_saturate", CNT_MAX);

        // Mid-frame reset clears the counter and flushes the pipeline
        step(0, 0, 1'b0, 1'b1);
        rand_scan(100, 100, 139, 50, 89, 0);
        do_reset(2);
        check_cnt_now("cnt_after_reset", 0);
        rand_scan(50, 100, 139, 50, 89, 0);
        set_spr(100, 50, 1'b1);
        step(0, 0, 1'b0, 1'b1);
        rand_scan(200, 90, 150, 40, 100, 0);
        do_reset(1);
        rand_scan(100, 90, 150, 40, 100, 0);
        idle(4);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending pixels required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shell_sprite_render.md
# shell_sprite_render

Pixel-pipeline stage that sits directly in front of and behind the 40×40 RGB565 shell sprite ROM. It turns the VGA scan position into a ROM address, aligns the ROM's one-cycle read latency, and applies colour-key transparency. It emits a registered pixel and a hit flag to the layer mixer, and counts opaque shell pixels per frame so the CPU can read them for collision logic.

## Interface
Parameters:
- SPR_W, 40, sprite width in pixels
- SPR_H, 40, sprite height in pixels
- ADDR_W, 11, ROM address width; must satisfy SPR_W*SPR_H <= 2^ADDR_W
- CRD_W, 11, screen coordinate width
- KEY, 16'hF81F, transparent colour (RGB565 magenta)

Ports:
- clk  in  1  pixel clock; ROM shares this clock
- rst_n  in  1  synchronous, active-low reset
- pix_x  in  CRD_W  current scan column
- pix_y  in  CRD_W  current scan row
- pix_valid  in  1  active-video qualifier for pix_x/pix_y
- frame_start  in  1  one-cycle pulse, once per frame, during blanking
- spr_x, spr_y  in  CRD_W each  sprite top-left corner from the CPU register file
- spr_en  in  1  sprite visible
- rom_addr  out  ADDR_W  address to ROM addra; registered
- rom_data  in  16  ROM doa; valid one cycle after rom_addr
- pix_rgb  out  16  shell pixel colour; 0 when not hit
- pix_hit  out  1  opaque shell pixel at this position
- out_valid  out  1  pix_valid delayed to align with pix_rgb
- opaque_cnt  out  ADDR_W+1  opaque pixel count of the previous frame

## Operation
- **Shadow registers**
  - spr_x_s, spr_y_s and spr_en_s load from spr_x, spr_y and spr_en only on the frame_start edge.
  - This prevents tearing when the CPU moves the sprite mid-frame.
  - A pixel sampled on the same edge as frame_start uses the old shadow values.
- **Stage 0 → 1 (edge N)**
  - in_box = pix_valid & spr_en_s & (pix_x >= spr_x_s) & (pix_x < spr_x_s+SPR_W) & (pix_y >= spr_y_s) & (pix_y < spr_y_s+SPR_H).
  - Both sums are computed at CRD_W+1 bits, so a sprite near the screen edge never wraps.
  - dx = pix_x-spr_x_s and dy = pix_y-spr_y_s.
  - rom_addr <= in_box ? dy*SPR_W+dx : 0. With SPR_W=40 this is implemented as (dy<<5)+(dy<<3)+dx, with no multiplier.
  - The range is 0..1599 when SPR_W=SPR_H=40.
  - in_box_d1 <= in_box and valid_d1 <= pix_valid.
- **Stage 1 → 2 (edge N+1)**
  - The ROM captures rom_addr; rom_data is valid after this edge.
  - in_box_d2 <= in_box_d1 and valid_d2 <= valid_d1.
- **Stage 2 → out (edge N+2)**
  - hit = in_box_d2 & (rom_data != KEY).
  - pix_hit <= hit.
  - pix_rgb <= hit ? rom_data : 16'h0000.
  - out_valid <= valid_d2.
- **Opaque counter**
  - acc increments on each edge where hit is registered.
  - On frame_start: opaque_cnt <= acc + (hit ? 1 : 0), and acc <= 0. The pixel completing on the frame_start edge is therefore counted in the closing frame.
  - acc saturates at 2^(ADDR_W+1)-1; it never wraps.
- No backpressure exists: the pipeline advances every clock.

## Timing
- Latency: inputs sampled at edge N appear on pix_rgb, pix_hit and out_valid after edge N+2.
  - The VGA sync generator delays hsync/vsync by 2 clocks to match.
- Throughput: one pixel per clock.
- Reset (rst_n=0 at an edge) clears all of the following to 0:
  - rom_addr, pix_rgb, pix_hit, out_valid and opaque_cnt
  - acc
  - the shadow registers (spr_en_s=0, so no hits until the first frame_start after reset)
  - all pipeline flags
- Reset asserted mid-line flushes the pipeline: the output is 0 for the two edges after release, regardless of the input.
- frame_start and pix_valid high together is legal and follows the shadow and counter rules above.
- While spr_en_s=0, pix_hit stays 0 but out_valid still tracks pix_valid.

## Test plan
- **Basic hit**
  - Stimulus: reset, then frame_start with spr_x=100, spr_y=50, spr_en=1; scan pix_x=100, pix_y=50.
  - Required: rom_addr=0 after edge N. After N+2, pix_hit=1 and pix_rgb equals ROM word 0 (if that word is not KEY).
- **Last pixel / first outside pixels**
  - Stimulus: same sprite; scan pix_x=139, pix_y=89.
  - Required: rom_addr=1599. Then pix_x=140 and, separately, pix_y=90 each give in_box=0, rom_addr=0, pix_hit=0 and pix_rgb=0.
- **Transparency**
  - Stimulus: preload a ROM word with 16'hF81F at an in-box address.
  - Required: pix_hit=0 and pix_rgb=0 while out_valid=1.
- **Edge wrap**
  - Stimulus: spr_x=2030 (CRD_W=11); scan pix_x=5.
  - Required: no hit. Scan pix_x=2047: hit at dx=17.
- **Shadow latching**
  - Stimulus: change spr_x from 100 to 300 mid-frame.
  - Required: the hit column stays at 100 until the next frame_start, then moves to 300.
- **Counter**
  - Stimulus: full frame over an all-opaque ROM with the sprite fully on screen, then frame_start.
  - Required: opaque_cnt=1600. The next frame with spr_en=0 yields opaque_cnt=0. Asserting rst_n low mid-frame clears opaque_cnt to 0.
